// File: rtl/pad_loader.sv
// Loads an 81-pixel (9x9) frame into the interior of an 11x11 zero-padded byte matrix.
// Defining LOAD_CHECKSUM_EN adds a 16-bit running checksum output.
module pad_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [967:0] matrix,
    output logic         busy,
    output logic         done,
    output logic [6:0]   pix_count
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [15:0]  checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t     state;
    logic [3:0] row;
    logic [3:0] col;
    logic [6:0] wr_idx;
    logic       accept;

    always_comb begin
        wr_idx = 7'(row) * 7'd11 + 7'(col);
        accept = pix_valid && pix_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            matrix    <= '0;
            row       <= 4'd1;
            col       <= 4'd1;
            pix_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        matrix    <= '0;
                        row       <= 4'd1;
                        col       <= 4'd1;
                        pix_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pix_ready <= 1'b1;
`ifdef LOAD_CHECKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // Only interior bytes are ever written, so the border stays zero.
                        matrix[{wr_idx, 3'b000} +: 8] <= pix_in;
                        pix_count <= pix_count + 7'd1;
`ifdef LOAD_CHECKSUM_EN
                        checksum  <= checksum + {8'h00, pix_in};
`endif
                        if (col == 4'd9) begin
                            col <= 4'd1;
                            row <= row + 4'd1;
                        end else begin
                            col <= col + 4'd1;
                        end
                        if (pix_count == 7'd80) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pad_loader.md
PAD_LOADER -- requirements
Module: pad_loader

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset (rst=0 resets).
REQ-003 SHALL have port start, input, 1: begin a new frame load.
REQ-004 SHALL have port pix_in, input, 8: unsigned pixel, row-major order.
REQ-005 SHALL have port pix_valid, input, 1: pix_in valid this cycle.
REQ-006 SHALL have port pix_ready, output, 1: block accepts a pixel this cycle.
REQ-007 SHALL have port matrix, output, 968: 11x11 zero-padded frame, byte (i*11+j) at bits [(i*11+j)*8 +: 8], i = row 0..10, j = col 0..10.
REQ-008 SHALL have port busy, output, 1: high while in LOAD.
REQ-009 SHALL have port done, output, 1: frame complete, matrix stable.
REQ-010 SHALL have port pix_count, output, 7: pixels accepted in current frame, 0..81.
REQ-011 SHALL have port checksum, output, 16: present only when LOAD_CHECKSUM_EN is defined.

Function
REQ-012 SHALL implement three states: IDLE, LOAD, DONE.
REQ-013 SHALL, in IDLE or DONE, on start=1: clear all 121 matrix bytes to 0, set row=1 and col=1, clear pix_count (and checksum), and enter LOAD on the same edge.
REQ-014 SHALL ignore start while in LOAD.
REQ-015 SHALL drive pix_ready=1 only in LOAD; a pixel is accepted on an edge where pix_valid=1 and pix_ready=1.
REQ-016 SHALL write an accepted pixel to matrix byte (row*11+col), visible in the cycle after the accepting edge (1-cycle latency).
REQ-017 SHALL advance col 1..9 on each accept; after col=9, wrap col to 1 and increment row; row spans 1..9.
REQ-018 SHALL hold row, col, pix_count and matrix unchanged in cycles with pix_valid=0 (gaps allowed, any length).
REQ-019 SHALL enter DONE on the edge that accepts the 81st pixel; done=1 and busy=0 from the next cycle.
REQ-020 SHALL keep border bytes (row 0, row 10, col 0, col 10) at 0 at all times after reset or start.
REQ-021 SHALL hold done=1 and matrix unchanged in DONE until start or reset.
REQ-022 SHALL ignore pix_valid in IDLE and DONE; pix_count and matrix stay unchanged.
REQ-023 SHALL drive busy=1 exactly in LOAD and done=1 exactly in DONE, both registered.

Reset
REQ-024 SHALL, on rst=0, immediately and asynchronously force state IDLE, matrix=0, pix_count=0, busy=0, done=0, pix_ready=0, and checksum=0 if present.
REQ-025 SHALL abort an in-progress load on reset; no partial frame is retained.
REQ-026 SHALL leave IDLE only on a start sampled after rst returns to 1.

Configuration
REQ-027 SHALL, with LOAD_CHECKSUM_EN defined, expose checksum as the 16-bit wrapping sum of all pixels accepted in the current frame, updated with the same 1-cycle latency as matrix and cleared on start.
REQ-028 SHALL, without LOAD_CHECKSUM_EN, omit the checksum port and its adder; all other behaviour is identical.

Verification
REQ-029 SHALL cover: rst=0 pulse mid-simulation -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
REQ-030 SHALL cover: start, then 81 back-to-back pixels k=1..81 -> done=1 one cycle after the 81st accept; byte (1*11+1)=1; byte (9*11+9)=81; byte (5*11+3)=39; all 40 border bytes 0; pix_count=81; checksum=3321 (macro on).
REQ-031 SHALL cover: the same 81 pixels with random pix_valid gaps -> identical matrix and checksum; pix_count constant during gaps.
REQ-032 SHALL cover: start pulsed after 20 pixels in LOAD -> ignored; the frame completes with pixels 1..81 intact. Also pix_valid=1 with pix_in=0xFF in IDLE and in DONE -> no change.
REQ-033 SHALL cover: rst=0 after 40 pixels, release, start, then 81 pixels of 0xFF -> interior all 0xFF, border 0, checksum=20655.
REQ-034 SHALL cover: in DONE, start, then 81 pixels of 0x02 -> all previous values cleared; interior all 0x02; checksum=162.
